axis_audio_arbiter: RTL and testbench

//   Packet-level arbiter sharing the I2S transmit AXIS port (2-word stereo packets: L then R, last on R) between two sources.

---
 rtl/axis_audio_arbiter.sv | 175 +++++++++++++++++
 tb/tb_axis_audio_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/axis_audio_arbiter.sv
// Packet-level arbiter for two stereo AXIS audio sources feeding one I2S tx port.
// Whole 2-word packets (L, R+last) are granted; packet length is forced to two
// words, overlong packets are drained, and per-source mute zeroes forwarded data.
module axis_audio_arbiter #(
  parameter int DATA_W = 24,
  parameter int CNT_W  = 16
) (
  input  logic              axis_clk,
  input  logic              axis_reset,
  input  logic [DATA_W-1:0] s0_axis_data,
  input  logic              s0_axis_valid,
  output logic              s0_axis_ready,
  input  logic              s0_axis_last,
  input  logic [DATA_W-1:0] s1_axis_data,
  input  logic              s1_axis_valid,
  output logic              s1_axis_ready,
  input  logic              s1_axis_last,
  output logic [DATA_W-1:0] m_axis_data,
  output logic              m_axis_valid,
  input  logic              m_axis_ready,
  output logic              m_axis_last,
  input  logic              cfg_prio,
  input  logic [1:0]        cfg_mute,
  output logic              grant,
  output logic              busy,
  output logic              err_short,
  output logic              err_long,
  output logic [CNT_W-1:0]  pkt_cnt0,
  output logic [CNT_W-1:0]  pkt_cnt1
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_XFER = 2'd1, ST_DRAIN = 2'd2} state_t;

  state_t             state_r, next_s;
  logic               grant_r;
  logic               mute_r;
  logic               word_idx_r;
  logic               err_short_r, err_long_r;
  logic [CNT_W-1:0]   pkt_cnt0_r, pkt_cnt1_r;

  logic               win_s;
  logic               sel_valid_s, sel_last_s;
  logic [DATA_W-1:0]  sel_data_s;
  logic               pkt_done_s, set_short_s, set_long_s, word_idx_next_s;

  assign grant     = grant_r;
  assign busy      = (state_r != ST_IDLE);
  assign err_short = err_short_r;
  assign err_long  = err_long_r;
  assign pkt_cnt0  = pkt_cnt0_r;
  assign pkt_cnt1  = pkt_cnt1_r;

  // Arbitration: fixed priority to s0, or round-robin alternating on contention
  always_comb begin
    win_s = 1'b0;
    if (cfg_prio) begin
      win_s = s0_axis_valid ? 1'b0 : 1'b1;
    end else if (s0_axis_valid && s1_axis_valid) begin
      win_s = ~grant_r;
    end else if (s0_axis_valid) begin
      win_s = 1'b0;
    end else begin
      win_s = 1'b1;
    end
  end

  // Next state, pass-through datapath and per-transfer bookkeeping strobes
  always_comb begin
    next_s          = state_r;
    s0_axis_ready   = 1'b0;
    s1_axis_ready   = 1'b0;
    m_axis_valid    = 1'b0;
    m_axis_last     = 1'b0;
    m_axis_data     = {DATA_W{1'b0}};
    pkt_done_s      = 1'b0;
    set_short_s     = 1'b0;
    set_long_s      = 1'b0;
    word_idx_next_s = word_idx_r;
    sel_valid_s     = grant_r ? s1_axis_valid : s0_axis_valid;
    sel_last_s      = grant_r ? s1_axis_last  : s0_axis_last;
    sel_data_s      = grant_r ? s1_axis_data  : s0_axis_data;
    case (state_r)
      ST_IDLE: begin
        if (s0_axis_valid || s1_axis_valid) begin
          next_s = ST_XFER;
        end else begin
          next_s = ST_IDLE;
        end
      end
      ST_XFER: begin
        m_axis_valid  = sel_valid_s;
        m_axis_data   = mute_r ? {DATA_W{1'b0}} : sel_data_s;
        // Second word always carries last so downstream never sees >2 words
        m_axis_last   = sel_last_s | word_idx_r;
        s0_axis_ready = ~grant_r & m_axis_ready;
        s1_axis_ready =  grant_r & m_axis_ready;
        if (sel_valid_s && m_axis_ready) begin
          if (!word_idx_r) begin
            if (sel_last_s) begin
              set_short_s = 1'b1;
              pkt_done_s  = 1'b1;
              next_s      = ST_IDLE;
            end else begin
              word_idx_next_s = 1'b1;
            end
          end else begin
            word_idx_next_s = 1'b0;
            pkt_done_s      = 1'b1;
            if (sel_last_s) begin
              next_s = ST_IDLE;
            end else begin
              set_long_s = 1'b1;
              next_s     = ST_DRAIN;
            end
          end
        end else begin
          word_idx_next_s = word_idx_r;
        end
      end
      ST_DRAIN: begin
        // Swallow the rest of an overlong packet without forwarding it
        s0_axis_ready = ~grant_r;
        s1_axis_ready =  grant_r;
        if (sel_valid_s && sel_last_s) begin
          next_s = ST_IDLE;
        end else begin
          next_s = ST_DRAIN;
        end
      end
      default: begin
        next_s = ST_IDLE;
      end
    endcase
  end

  // State, grant/mute latch, word index and sticky error registers
  always_ff @(posedge axis_clk) begin
    if (axis_reset) begin
      state_r     <= ST_IDLE;
      grant_r     <= 1'b1;
      mute_r      <= 1'b0;
      word_idx_r  <= 1'b0;
      err_short_r <= 1'b0;
      err_long_r  <= 1'b0;
    end else begin
      state_r    <= next_s;
      word_idx_r <= word_idx_next_s;
      if ((state_r == ST_IDLE) && (s0_axis_valid || s1_axis_valid)) begin
        grant_r <= win_s;
        mute_r  <= cfg_mute[win_s];
      end
      if (set_short_s) begin
        err_short_r <= 1'b1;
      end
      if (set_long_s) begin
        err_long_r <= 1'b1;
      end
    end
  end

  // Per-source completed packet counters, wrapping on overflow
  always_ff @(posedge axis_clk) begin
    if (axis_reset) begin
      pkt_cnt0_r <= {CNT_W{1'b0}};
      pkt_cnt1_r <= {CNT_W{1'b0}};
    end else if (pkt_done_s) begin
      if (grant_r) begin
        pkt_cnt1_r <= pkt_cnt1_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        pkt_cnt0_r <= pkt_cnt0_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_axis_audio_arbiter.sv
// Directed self-checking bench for axis_audio_arbiter.
module tb_axis_audio_arbiter;

  localparam int DATA_W = 24;
  localparam int CNT_W  = 16;

  logic              axis_clk = 1'b0;
  logic              axis_reset;
  logic [DATA_W-1:0] s0_axis_data, s1_axis_data, m_axis_data;
  logic              s0_axis_valid, s0_axis_ready, s0_axis_last;
  logic              s1_axis_valid, s1_axis_ready, s1_axis_last;
  logic              m_axis_valid, m_axis_ready, m_axis_last;
  logic              cfg_prio;
  logic [1:0]        cfg_mute;
  logic              grant, busy, err_short, err_long;
  logic [CNT_W-1:0]  pkt_cnt0, pkt_cnt1;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] l_dat [2];
  logic [DATA_W-1:0] r_dat [2];

  axis_audio_arbiter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .axis_clk(axis_clk), .axis_reset(axis_reset),
    .s0_axis_data(s0_axis_data), .s0_axis_valid(s0_axis_valid),
    .s0_axis_ready(s0_axis_ready), .s0_axis_last(s0_axis_last),
    .s1_axis_data(s1_axis_data), .s1_axis_valid(s1_axis_valid),
    .s1_axis_ready(s1_axis_ready), .s1_axis_last(s1_axis_last),
    .m_axis_data(m_axis_data), .m_axis_valid(m_axis_valid),
    .m_axis_ready(m_axis_ready), .m_axis_last(m_axis_last),
    .cfg_prio(cfg_prio), .cfg_mute(cfg_mute),
    .grant(grant), .busy(busy), .err_short(err_short), .err_long(err_long),
    .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
  );

  always #5 axis_clk = ~axis_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge axis_clk);
    #1;
  endtask

  task automatic set_src(input int src, input logic [DATA_W-1:0] d, input logic lst);
    if (src == 0) begin
      s0_axis_data = d;
      s0_axis_last = lst;
    end else begin
      s1_axis_data = d;
      s1_axis_last = lst;
    end
  endtask

  task automatic do_reset();
    axis_reset = 1'b1;
    step();
    step();
    axis_reset = 1'b0;
  endtask

  // Called in IDLE with the source presenting its L word; runs one full packet.
  task automatic pkt(input int src, input logic [DATA_W-1:0] el, input logic [DATA_W-1:0] er);
    chk("idle_valid", {31'd0, m_axis_valid}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    step();
    chk("pkt_grant", {31'd0, grant}, src[31:0]);
    chk("pkt_l_data", {8'd0, m_axis_data}, {8'd0, el});
    chk("pkt_l_last", {31'd0, m_axis_last}, 32'd0);
    chk("pkt_other_rdy", {31'd0, (src == 0) ? s1_axis_ready : s0_axis_ready}, 32'd0);
    step();
    set_src(src, r_dat[src], 1'b1);
    #1;
    chk("pkt_r_data", {8'd0, m_axis_data}, {8'd0, er});
    chk("pkt_r_last", {31'd0, m_axis_last}, 32'd1);
    step();
    set_src(src, l_dat[src], 1'b0);
    #1;
  endtask

  initial begin
    axis_reset = 1'b1;
    s0_axis_data = 24'd0; s0_axis_valid = 1'b0; s0_axis_last = 1'b0;
    s1_axis_data = 24'd0; s1_axis_valid = 1'b0; s1_axis_last = 1'b0;
    m_axis_ready = 1'b1; cfg_prio = 1'b0; cfg_mute = 2'b00;
    l_dat[0] = 24'h123456; r_dat[0] = 24'hABCDEF;
    l_dat[1] = 24'h200000; r_dat[1] = 24'h200001;
    do_reset();

    // Reset values
    chk("rst_grant", {31'd0, grant}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_m_valid", {31'd0, m_axis_valid}, 32'd0);
    chk("rst_m_last", {31'd0, m_axis_last}, 32'd0);
    chk("rst_errs", {30'd0, err_short, err_long}, 32'd0);
    chk("rst_cnt0", {16'd0, pkt_cnt0}, 32'd0);

    // Source 0 only: two packets with an idle cycle between them
    s0_axis_valid = 1'b1;
    set_src(0, l_dat[0], 1'b0);
    #1;
    chk("idle_s0_ready", {31'd0, s0_axis_ready}, 32'd0);
    pkt(0, 24'h123456, 24'hABCDEF);
    chk("s0_cnt_1", {16'd0, pkt_cnt0}, 32'd1);
    pkt(0, 24'h123456, 24'hABCDEF);
    chk("s0_cnt_2", {16'd0, pkt_cnt0}, 32'd2);
    s0_axis_valid = 1'b0;

    // Round-robin with both sources always valid
    l_dat[0] = 24'h100000; r_dat[0] = 24'h100001;
    do_reset();
    set_src(0, l_dat[0], 1'b0);
    set_src(1, l_dat[1], 1'b0);
    s0_axis_valid = 1'b1;
    s1_axis_valid = 1'b1;
    #1;
    pkt(0, 24'h100000, 24'h100001);
    pkt(1, 24'h200000, 24'h200001);
    pkt(0, 24'h100000, 24'h100001);
    pkt(1, 24'h200000, 24'h200001);
    chk("rr_cnt0", {16'd0, pkt_cnt0}, 32'd2);
    chk("rr_cnt1", {16'd0, pkt_cnt1}, 32'd2);

    // Fixed priority: s0 always wins, s1 never served
    do_reset();
    cfg_prio = 1'b1;
    #1;
    pkt(0, 24'h100000, 24'h100001);
    pkt(0, 24'h100000, 24'h100001);
    pkt(0, 24'h100000, 24'h100001);
    chk("prio_cnt0", {16'd0, pkt_cnt0}, 32'd3);
    chk("prio_cnt1", {16'd0, pkt_cnt1}, 32'd0);
    s0_axis_valid = 1'b0;
    s1_axis_valid = 1'b0;
    cfg_prio = 1'b0;

    // Mute on source 1; toggling mute mid-packet has no effect
    do_reset();
    cfg_mute = 2'b10;
    set_src(1, 24'h7FFFFF, 1'b0);
    s1_axis_valid = 1'b1;
    step();
    chk("mute_grant", {31'd0, grant}, 32'd1);
    chk("mute_l_valid", {31'd0, m_axis_valid}, 32'd1);
    chk("mute_l_data", {8'd0, m_axis_data}, 32'd0);
    chk("mute_l_last", {31'd0, m_axis_last}, 32'd0);
    cfg_mute = 2'b00;
    step();
    set_src(1, 24'h800000, 1'b1);
    #1;
    chk("mute_r_data", {8'd0, m_axis_data}, 32'd0);
    chk("mute_r_last", {31'd0, m_axis_last}, 32'd1);
    step();
    s1_axis_valid = 1'b0;
    chk("mute_cnt1", {16'd0, pkt_cnt1}, 32'd1);

    // Overlong packet from s0: last forced on word 2, words 3-4 drained
    do_reset();
    set_src(0, 24'h000001, 1'b0);
    s0_axis_valid = 1'b1;
    step();
    chk("long_w1_data", {8'd0, m_axis_data}, 32'h1);
    step();
    set_src(0, 24'h000002, 1'b0);
    #1;
    chk("long_w2_data", {8'd0, m_axis_data}, 32'h2);
    chk("long_w2_last", {31'd0, m_axis_last}, 32'd1);
    step();
    chk("long_err", {31'd0, err_long}, 32'd1);
    chk("long_drain_valid", {31'd0, m_axis_valid}, 32'd0);
    chk("long_drain_ready", {31'd0, s0_axis_ready}, 32'd1);
    chk("long_cnt0", {16'd0, pkt_cnt0}, 32'd1);
    set_src(0, 24'h000003, 1'b0);
    step();
    set_src(0, 24'h000004, 1'b1);
    #1;
    chk("long_w4_valid", {31'd0, m_axis_valid}, 32'd0);
    chk("long_w4_ready", {31'd0, s0_axis_ready}, 32'd1);
    chk("long_w4_busy", {31'd0, busy}, 32'd1);
    step();
    s0_axis_valid = 1'b0;
    chk("long_idle", {31'd0, busy}, 32'd0);
    chk("long_cnt0_end", {16'd0, pkt_cnt0}, 32'd1);

    // Short packet from s1, then reset in the middle of the next packet
    set_src(1, 24'h555555, 1'b1);
    s1_axis_valid = 1'b1;
    step();
    chk("short_grant", {31'd0, grant}, 32'd1);
    chk("short_data", {8'd0, m_axis_data}, 32'h555555);
    chk("short_last", {31'd0, m_axis_last}, 32'd1);
    step();
    chk("short_err", {31'd0, err_short}, 32'd1);
    chk("short_long_sticky", {31'd0, err_long}, 32'd1);
    chk("short_cnt1", {16'd0, pkt_cnt1}, 32'd1);
    set_src(1, 24'h111111, 1'b0);
    step();
    chk("mid_busy", {31'd0, busy}, 32'd1);
    step();
    chk("mid_valid", {31'd0, m_axis_valid}, 32'd1);
    axis_reset = 1'b1;
    step();
    chk("mrst_valid", {31'd0, m_axis_valid}, 32'd0);
    chk("mrst_last", {31'd0, m_axis_last}, 32'd0);
    chk("mrst_s1_ready", {31'd0, s1_axis_ready}, 32'd0);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_grant", {31'd0, grant}, 32'd1);
    chk("mrst_errs", {30'd0, err_short, err_long}, 32'd0);
    chk("mrst_cnts", {pkt_cnt1, pkt_cnt0}, 32'd0);
    axis_reset = 1'b0;
    s1_axis_valid = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
